alarm_timekeeper: RTL and testbench
===================================

// Module: alarm_timekeeper
// PURPOSE
// Time-of-day keeper and alarm sequencer for the alarm control system. Sits directly
// downstream of the 1 Hz clock divider, which feeds it one Clock-wide 1 Hz enable
// pulses. Keeps HH:MM:SS in BCD, holds one HH:MM alarm time, and runs the
// ring/snooze state machine that drives the buzzer and display status.
// PARAMETERS
// ALARM_SECONDS   60   ticks a ring lasts before auto-stop (range 1..4095)
// SNOOZE_SECONDS  300  ticks spent in snooze before ringing again (range 1..4095)
// PORTS
// Clock       in   1   system clock; all state updates on posedge
// Reset       in   1   asynchronous, active-high reset
// tick        in   1   1 Hz enable, high for exactly one Clock cycle per second
// time_load   in   1   load time_in into the time register this cycle
// time_in     in   24  BCD {H1,H0,M1,M0,S1,S0}
// alarm_load  in   1   load alarm_in into the alarm register this cycle
// alarm_in    in   16  BCD {H1,H0,M1,M0}
// alarm_en    in   1   level; alarm armed while high
// snooze      in   1   one-cycle request: ringing -> snooze
// stop        in   1   one-cycle request: cancel ring/snooze
// time_bcd    out  24  current time, BCD {H1,H0,M1,M0,S1,S0}
// alarm_bcd   out  16  stored alarm time, BCD {H1,H0,M1,M0}
// ringing     out  1   high while state = RINGING
// snoozing    out  1   high while state = SNOOZE
// BEHAVIOUR
// - Reset (async, Reset=1): time_bcd=24'h000000, alarm_bcd=16'h0000, ringing=0,
//   snoozing=0, state=IDLE, ring/snooze counters=0. Clears immediately, any state.
// - Time counting: on each tick, SS+1; 59->00 carries to MM; MM 59->00 carries to HH;
//   23:59:59 -> 00:00:00. Each BCD digit stays 0-9; no binary intermediate exposed.
// - time_load: registers time_in on that edge if valid (H<=23, M<=59, S<=59, all
//   digits 0-9); invalid value ignored, register unchanged. Load beats tick in the
//   same cycle (tick dropped, no increment). Loading never triggers the alarm.
// - alarm_load: same rule (H<=23, M<=59); invalid ignored. Ring in progress unaffected.
// - Outputs are registered; time_bcd/alarm_bcd change one edge after tick/load.
// - Trigger: on a tick edge where the incremented time equals {alarm_bcd,8'h00},
//   alarm_en=1, and state=IDLE: IDLE->RINGING on that same edge (ringing rises
//   together with time_bcd showing HH:MM:00). Trigger in RINGING/SNOOZE ignored.
// - FSM: states IDLE, RINGING, SNOOZE; 12-bit down-counter cnt.
//   IDLE->RINGING: trigger; cnt<=ALARM_SECONDS.
//   RINGING: tick decrements cnt; tick with cnt==1 -> IDLE (ring spans exactly
//     ALARM_SECONDS ticks after entry). snooze -> SNOOZE, cnt<=SNOOZE_SECONDS.
//   SNOOZE: tick decrements cnt; tick with cnt==1 -> RINGING, cnt<=ALARM_SECONDS.
//   stop in RINGING or SNOOZE -> IDLE. snooze in IDLE/SNOOZE ignored.
// - Priority in one cycle: alarm_en=0 > stop > snooze > tick expiry. alarm_en low
//   forces IDLE from any state on the next edge; re-arming does not ring until next match.
// - snooze and tick same cycle in RINGING: snooze wins; cnt<=SNOOZE_SECONDS (no decrement).
// - Reset mid-ring/snooze: returns to IDLE, outputs low, time cleared to 00:00:00.
// TESTING
// 1 Reset: assert Reset mid-run -> all outputs zero with no Clock edge; IDLE after release.
// 2 Rollover: load 24'h235958, 2 ticks -> 23:59:59 then 00:00:00; load 24'h236000
//   and 24'h0A0000 -> rejected, time unchanged; time_load+tick same cycle -> loaded value.
// 3 Trigger: alarm 16'h0700, en=1, time 06:59:58; 2 ticks -> ringing rises with time
//   07:00:00; ALARM_SECONDS=4: 4 more ticks -> ringing falls on 4th.
// 4 Snooze: while ringing pulse snooze -> snoozing=1, ringing=0; SNOOZE_SECONDS=3:
//   3 ticks -> ringing=1, snoozing=0; pulse stop -> both 0.
// 5 Priority: stop+snooze same cycle while ringing -> IDLE; alarm_en=0 while snoozing ->
//   IDLE next edge; alarm_en=0 at match time -> no ring.
// 6 Tick spacing: ticks on consecutive Clock cycles and 1 Hz spacing give identical
//   time sequences; no increment without tick.

Source files
------------

// File: rtl/alarm_timekeeper.sv
// BCD time-of-day keeper with one HH:MM alarm and a ring/snooze sequencer.
// Advances on 1 Hz enable pulses; all state is held in flops on the Clock domain.
module alarm_timekeeper #(
  parameter int ALARM_SECONDS  = 60,
  parameter int SNOOZE_SECONDS = 300
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        tick,
  input  logic        time_load,
  input  logic [23:0] time_in,
  input  logic        alarm_load,
  input  logic [15:0] alarm_in,
  input  logic        alarm_en,
  input  logic        snooze,
  input  logic        stop,
  output logic [23:0] time_bcd,
  output logic [15:0] alarm_bcd,
  output logic        ringing,
  output logic        snoozing
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RINGING = 2'd1,
    SNOOZE  = 2'd2
  } state_t;

  localparam logic [11:0] ALARM_CNT  = 12'(ALARM_SECONDS);
  localparam logic [11:0] SNOOZE_CNT = 12'(SNOOZE_SECONDS);

  state_t      state, state_next;
  logic [11:0] cnt, cnt_next;
  logic [23:0] time_inc;
  logic        time_ok, alarm_ok, trigger;

  function automatic logic hhmm_valid(input logic [15:0] v);
    logic [3:0] h1, h0, m1, m0;
    {h1, h0, m1, m0} = v;
    return (h1 <= 4'd2) && (h0 <= 4'd9) && !((h1 == 4'd2) && (h0 > 4'd3)) &&
           (m1 <= 4'd5) && (m0 <= 4'd9);
  endfunction

  // Digit-wise BCD increment with carries; 23:59:59 wraps to 00:00:00.
  function automatic logic [23:0] bcd_inc(input logic [23:0] t);
    logic [3:0] h1, h0, m1, m0, s1, s0;
    {h1, h0, m1, m0, s1, s0} = t;
    if (s0 != 4'd9) begin
      s0 = s0 + 4'd1;
    end else begin
      s0 = 4'd0;
      if (s1 != 4'd5) begin
        s1 = s1 + 4'd1;
      end else begin
        s1 = 4'd0;
        if (m0 != 4'd9) begin
          m0 = m0 + 4'd1;
        end else begin
          m0 = 4'd0;
          if (m1 != 4'd5) begin
            m1 = m1 + 4'd1;
          end else begin
            m1 = 4'd0;
            if ((h1 == 4'd2) && (h0 == 4'd3)) begin
              h1 = 4'd0;
              h0 = 4'd0;
            end else if (h0 == 4'd9) begin
              h0 = 4'd0;
              h1 = h1 + 4'd1;
            end else begin
              h0 = h0 + 4'd1;
            end
          end
        end
      end
    end
    return {h1, h0, m1, m0, s1, s0};
  endfunction

  assign time_inc = bcd_inc(time_bcd);
  assign time_ok  = hhmm_valid(time_in[23:8]) && (time_in[7:4] <= 4'd5) &&
                    (time_in[3:0] <= 4'd9);
  assign alarm_ok = hhmm_valid(alarm_in);

  // A load that claims the cycle swallows the tick, so it can never cause a match.
  assign trigger = tick && !time_load && alarm_en && (state == IDLE) &&
                   (time_inc == {alarm_bcd, 8'h00});

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      time_bcd  <= 24'h000000;
      alarm_bcd <= 16'h0000;
    end else begin
      if (time_load) begin
        if (time_ok) time_bcd <= time_in;
      end else if (tick) begin
        time_bcd <= time_inc;
      end
      if (alarm_load && alarm_ok) alarm_bcd <= alarm_in;
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state <= IDLE;
      cnt   <= 12'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // Disarm beats stop, stop beats snooze, snooze beats tick expiry.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    if (!alarm_en) begin
      state_next = IDLE;
      cnt_next   = 12'd0;
    end else begin
      case (state)
        IDLE: begin
          if (trigger) begin
            state_next = RINGING;
            cnt_next   = ALARM_CNT;
          end
        end
        RINGING: begin
          if (stop) begin
            state_next = IDLE;
            cnt_next   = 12'd0;
          end else if (snooze) begin
            state_next = SNOOZE;
            cnt_next   = SNOOZE_CNT;
          end else if (tick) begin
            if (cnt == 12'd1) begin
              state_next = IDLE;
              cnt_next   = 12'd0;
            end else begin
              cnt_next = cnt - 12'd1;
            end
          end
        end
        SNOOZE: begin
          if (stop) begin
            state_next = IDLE;
            cnt_next   = 12'd0;
          end else if (tick) begin
            if (cnt == 12'd1) begin
              state_next = RINGING;
              cnt_next   = ALARM_CNT;
            end else begin
              cnt_next = cnt - 12'd1;
            end
          end
        end
        default: begin
          state_next = IDLE;
          cnt_next   = 12'd0;
        end
      endcase
    end
  end

  assign ringing  = (state == RINGING);
  assign snoozing = (state == SNOOZE);

endmodule

// File: tb/tb_alarm_timekeeper.sv
// Directed self-checking bench for alarm_timekeeper with short ring/snooze lengths.
// Inputs change and outputs are sampled on the falling Clock edge.
module tb_alarm_timekeeper;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic        tick = 1'b0;
  logic        time_load = 1'b0;
  logic [23:0] time_in = 24'h0;
  logic        alarm_load = 1'b0;
  logic [15:0] alarm_in = 16'h0;
  logic        alarm_en = 1'b0;
  logic        snooze = 1'b0;
  logic        stop = 1'b0;
  logic [23:0] time_bcd;
  logic [15:0] alarm_bcd;
  logic        ringing;
  logic        snoozing;

  int test_count = 0;
  int fail_count = 0;

  alarm_timekeeper #(
    .ALARM_SECONDS (4),
    .SNOOZE_SECONDS(3)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .tick      (tick),
    .time_load (time_load),
    .time_in   (time_in),
    .alarm_load(alarm_load),
    .alarm_in  (alarm_in),
    .alarm_en  (alarm_en),
    .snooze    (snooze),
    .stop      (stop),
    .time_bcd  (time_bcd),
    .alarm_bcd (alarm_bcd),
    .ringing   (ringing),
    .snoozing  (snoozing)
  );

  always #5 Clock = ~Clock;

  task automatic check_output(input string tag, input logic [23:0] got, input logic [23:0] exp);
    test_count++;
    if (got !== exp) begin
      fail_count++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge Clock);
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    @(negedge Clock);
    tick = 1'b0;
  endtask

  task automatic load_time(input logic [23:0] v);
    time_in   = v;
    time_load = 1'b1;
    @(negedge Clock);
    time_load = 1'b0;
  endtask

  task automatic load_alarm(input logic [15:0] v);
    alarm_in   = v;
    alarm_load = 1'b1;
    @(negedge Clock);
    alarm_load = 1'b0;
  endtask

  task automatic pulse_snooze();
    snooze = 1'b1;
    @(negedge Clock);
    snooze = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    @(negedge Clock);
    stop = 1'b0;
  endtask

  // Arm 07:00, start at 06:59:59, one tick enters the ring.
  task automatic start_ring(input string tag);
    alarm_en = 1'b1;
    load_time(24'h065959);
    pulse_tick();
    check_output(tag, {23'd0, ringing}, 24'd1);
  endtask

  initial begin
    // Reset state
    wait_cycles(2);
    check_output("rst_time", time_bcd, 24'h000000);
    check_output("rst_alarm", {8'h00, alarm_bcd}, 24'h000000);
    check_output("rst_flags", {22'd0, ringing, snoozing}, 24'd0);
    Reset = 1'b0;
    wait_cycles(1);

    // Rollover and load validation
    load_time(24'h235958);
    check_output("load_235958", time_bcd, 24'h235958);
    pulse_tick();
    check_output("tick_235959", time_bcd, 24'h235959);
    pulse_tick();
    check_output("wrap_000000", time_bcd, 24'h000000);
    load_time(24'h236000);
    check_output("reject_236000", time_bcd, 24'h000000);
    load_time(24'h0A0000);
    check_output("reject_0A0000", time_bcd, 24'h000000);
    load_time(24'h240000);
    check_output("reject_240000", time_bcd, 24'h000000);
    tick = 1'b1;
    load_time(24'h123456);
    tick = 1'b0;
    check_output("load_beats_tick", time_bcd, 24'h123456);
    wait_cycles(3);
    check_output("no_tick_hold", time_bcd, 24'h123456);
    pulse_tick();
    check_output("tick_123457", time_bcd, 24'h123457);

    // Trigger and auto-stop after 4 ticks
    load_alarm(16'h0700);
    check_output("alarm_0700", {8'h00, alarm_bcd}, 24'h000700);
    load_alarm(16'h2400);
    check_output("alarm_reject", {8'h00, alarm_bcd}, 24'h000700);
    alarm_en = 1'b1;
    load_time(24'h065958);
    pulse_tick();
    check_output("pre_match_time", time_bcd, 24'h065959);
    check_output("pre_match_ring", {23'd0, ringing}, 24'd0);
    pulse_tick();
    check_output("match_time", time_bcd, 24'h070000);
    check_output("match_ring", {23'd0, ringing}, 24'd1);
    for (int i = 1; i <= 3; i++) begin
      pulse_tick();
      check_output($sformatf("ring_hold_%0d", i), {23'd0, ringing}, 24'd1);
    end
    pulse_tick();
    check_output("ring_end", {22'd0, ringing, snoozing}, 24'd0);

    // Snooze then re-ring, then stop
    start_ring("ring2_start");
    pulse_snooze();
    check_output("snooze_enter", {22'd0, ringing, snoozing}, 24'd1);
    for (int i = 1; i <= 2; i++) begin
      pulse_tick();
      check_output($sformatf("snooze_hold_%0d", i), {22'd0, ringing, snoozing}, 24'd1);
    end
    pulse_tick();
    check_output("snooze_expire", {22'd0, ringing, snoozing}, 24'd2);
    pulse_stop();
    check_output("stop_ring", {22'd0, ringing, snoozing}, 24'd0);

    // snooze together with tick while ringing reloads the snooze count
    start_ring("ring3_start");
    tick = 1'b1;
    pulse_snooze();
    tick = 1'b0;
    check_output("snooze_tick_enter", {22'd0, ringing, snoozing}, 24'd1);
    pulse_tick();
    pulse_tick();
    check_output("snooze_tick_hold", {22'd0, ringing, snoozing}, 24'd1);
    pulse_tick();
    check_output("snooze_tick_expire", {22'd0, ringing, snoozing}, 24'd2);
    pulse_stop();

    // Priority: stop beats snooze
    start_ring("ring4_start");
    stop = 1'b1;
    pulse_snooze();
    stop = 1'b0;
    check_output("stop_over_snooze", {22'd0, ringing, snoozing}, 24'd0);

    // alarm_en low while snoozing forces IDLE; re-arming does not ring
    start_ring("ring5_start");
    pulse_snooze();
    alarm_en = 1'b0;
    wait_cycles(1);
    check_output("disarm_snooze", {22'd0, ringing, snoozing}, 24'd0);
    alarm_en = 1'b1;
    for (int i = 0; i < 4; i++) pulse_tick();
    check_output("rearm_no_ring", {22'd0, ringing, snoozing}, 24'd0);

    // Disarmed at match time, and a load onto the alarm time: no ring
    alarm_en = 1'b0;
    load_time(24'h065959);
    pulse_tick();
    check_output("disarmed_match_time", time_bcd, 24'h070000);
    check_output("disarmed_match_ring", {23'd0, ringing}, 24'd0);
    alarm_en = 1'b1;
    load_time(24'h070000);
    wait_cycles(1);
    check_output("load_no_trigger", {23'd0, ringing}, 24'd0);

    // Back-to-back ticks versus spaced ticks give the same sequence
    load_time(24'h000058);
    tick = 1'b1;
    @(negedge Clock);
    check_output("b2b_1", time_bcd, 24'h000059);
    @(negedge Clock);
    check_output("b2b_2", time_bcd, 24'h000100);
    @(negedge Clock);
    tick = 1'b0;
    check_output("b2b_3", time_bcd, 24'h000101);
    load_time(24'h000058);
    wait_cycles(4);
    pulse_tick();
    check_output("spaced_1", time_bcd, 24'h000059);
    wait_cycles(4);
    check_output("spaced_gap", time_bcd, 24'h000059);
    pulse_tick();
    check_output("spaced_2", time_bcd, 24'h000100);
    wait_cycles(4);
    pulse_tick();
    check_output("spaced_3", time_bcd, 24'h000101);

    // Asynchronous reset mid-ring clears without a Clock edge
    start_ring("ring6_start");
    #2 Reset = 1'b1;
    #1;
    check_output("async_rst_time", time_bcd, 24'h000000);
    check_output("async_rst_alarm", {8'h00, alarm_bcd}, 24'h000000);
    check_output("async_rst_flags", {22'd0, ringing, snoozing}, 24'd0);
    @(negedge Clock);
    Reset = 1'b0;
    wait_cycles(2);
    check_output("post_rst_idle", {22'd0, ringing, snoozing}, 24'd0);
    check_output("post_rst_time", time_bcd, 24'h000000);

    $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
    $finish;
  end

endmodule
